// File: rtl/triggered_keepback_pkg.sv
// Shared types and constants for the triggered keepback buffer.
// Optional statistics are enabled by defining KEEPBACK_STATS_EN.
package triggered_keepback_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } kb_state_t;

  // Word-type tag values produced by the hit-to-word formatter
  localparam int TAG_DATA = 0;
  localparam int TAG_BOD  = 2;
  localparam int TAG_EOD  = 3;

  // Default tag field placement for 64-bit readout words
  localparam int          TAG_W_DEF   = 4;
  localparam int          TAG_LSB_DEF = 60;
  localparam logic [3:0]  HDR_TAG_DEF = 4'(TAG_BOD);

endpackage

// File: rtl/keepback_fifo.sv
// Synchronous FIFO with two ordered write ports (wr0 lands before wr1)
// and one read port. The head word is presented combinationally from
// storage, so a word written in cycle N is visible in cycle N+1.
// level_next exposes the occupancy after the current edge so the parent
// can register its ready flag without an extra cycle of lag.
module keepback_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     wr0_en,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     not_empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic [$clog2(DEPTH):0]   level_next
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr1_addr;
  logic [1:0]        wr_cnt;
  logic              rd_do;

  assign not_empty = (level != '0);
  assign rd_do     = rd_en & not_empty;
  assign rd_data   = mem[rd_ptr];
  assign wr_cnt    = {1'b0, wr0_en} + {1'b0, wr1_en};
  // wr1 goes into the slot after wr0 only when wr0 is also writing
  assign wr1_addr  = wr_ptr + PTR_W'(wr0_en);

  // Occupancy after this edge: pushes minus pops
  always_comb begin
    level_next = level + LVL_W'(wr_cnt) - LVL_W'(rd_do);
  end

  // Storage, pointers and level; contents cleared so out_data reads zero in reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr0_en) mem[wr_ptr]   <= wr0_data;
      if (wr1_en) mem[wr1_addr] <= wr1_data;
      wr_ptr <= wr_ptr + PTR_W'(wr_cnt);
      rd_ptr <= rd_ptr + PTR_W'(rd_do);
      level  <= level_next;
    end
  end

endmodule

// File: rtl/triggered_keepback_buffer.sv
// Triggered keepback buffer: holds each BoD header until a data word of
// the same event arrives, discarding headers that are immediately
// followed by another header (empty events). Output goes through a
// DEPTH-entry FIFO with valid/ready backpressure.
// Define KEEPBACK_STATS_EN to add the empty_evt_cnt / event_cnt outputs.
//
// state | meaning
// IDLE  | no header pending; data words are forwarded as they arrive
// HELD  | a header sits in the hold register waiting for its first data word
module triggered_keepback_buffer
  import triggered_keepback_pkg::*;
#(
  parameter int                 DATA_W  = 64,
  parameter int                 TAG_W   = TAG_W_DEF,
  parameter int                 TAG_LSB = TAG_LSB_DEF,
  parameter logic [TAG_W-1:0]   HDR_TAG = TAG_W'(TAG_BOD),
  parameter int                 DEPTH   = 8,
  parameter int                 CNT_W   = 32
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fifo_level
`ifdef KEEPBACK_STATS_EN
  ,
  output logic [CNT_W-1:0]         empty_evt_cnt,
  output logic [CNT_W-1:0]         event_cnt
`endif
);

  localparam int LVL_W = $clog2(DEPTH) + 1;

  kb_state_t         state;
  kb_state_t         state_next;
  logic [DATA_W-1:0] hold_data;
  logic              hold_load;
  logic              accept;
  logic              is_hdr;
  logic              push0;
  logic              push1;
  logic [DATA_W-1:0] push0_data;
  logic [DATA_W-1:0] push1_data;
  logic [LVL_W-1:0]  level_next;
  logic              ready_q;

  assign accept   = in_valid & ready_q;
  assign is_hdr   = (in_data[TAG_LSB +: TAG_W] == HDR_TAG);
  assign in_ready = ready_q;

  // Push selection and next state; a header+data pair uses both write ports
  always_comb begin
    state_next = state;
    hold_load  = 1'b0;
    push0      = 1'b0;
    push1      = 1'b0;
    push0_data = in_data;
    push1_data = in_data;
    if (!enable) begin
      // Pass-through; a header still held when enable drops is abandoned
      push0      = accept;
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            if (is_hdr) begin
              hold_load  = 1'b1;
              state_next = HELD;
            end else begin
              push0 = 1'b1;
            end
          end
        end
        HELD: begin
          if (accept) begin
            if (is_hdr) begin
              hold_load = 1'b1;
            end else begin
              push0      = 1'b1;
              push0_data = hold_data;
              push1      = 1'b1;
              state_next = IDLE;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // State and hold register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      hold_data <= '0;
    end else begin
      state <= state_next;
      if (hold_load) hold_data <= in_data;
    end
  end

  // Ready is the registered "room for two pushes" flag, held low in reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= (int'(level_next) <= DEPTH - 2);
    end
  end

  keepback_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset_n    (reset_n),
    .wr0_en     (push0),
    .wr0_data   (push0_data),
    .wr1_en     (push1),
    .wr1_data   (push1_data),
    .rd_en      (out_ready),
    .rd_data    (out_data),
    .not_empty  (out_valid),
    .level      (fifo_level),
    .level_next (level_next)
  );

`ifdef KEEPBACK_STATS_EN
  logic empty_inc;
  logic event_inc;

  // Discard: header replaced by another header, or dropped on enable fall
  assign empty_inc = (state == HELD) & (~enable | (accept & is_hdr));
  assign event_inc = (state == HELD) & enable & accept & ~is_hdr;

  // Saturating event statistics
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      empty_evt_cnt <= '0;
      event_cnt     <= '0;
    end else begin
      if (empty_inc && (empty_evt_cnt != '1)) empty_evt_cnt <= empty_evt_cnt + 1'b1;
      if (event_inc && (event_cnt != '1))     event_cnt     <= event_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_triggered_keepback_buffer.sv
// Scoreboard bench for triggered_keepback_buffer (DATA_W=64, DEPTH=8).
module tb_triggered_keepback_buffer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b1;
  logic [63:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [3:0]  fifo_level;
`ifdef KEEPBACK_STATS_EN
  logic [31:0] empty_evt_cnt;
  logic [31:0] event_cnt;
`endif

  int          total = 0;
  int          bad = 0;
  int          peak = 0;
  logic [63:0] exp_q[$];

  triggered_keepback_buffer dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fifo_level (fifo_level)
`ifdef KEEPBACK_STATS_EN
    ,
    .empty_evt_cnt (empty_evt_cnt),
    .event_cnt     (event_cnt)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: a pop happens at the next rising edge when valid & ready
  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_word actual=%h required=none", out_data);
      end else begin
        check("out_word", out_data, exp_q.pop_front());
      end
    end
    if (int'(fifo_level) > peak) peak = int'(fifo_level);
  end

  task automatic expect_w(input logic [63:0] w);
    exp_q.push_back(w);
  endtask

  // Present a word and hold it until accepted; returns at edge+1
  task automatic send(input logic [63:0] w);
    int n;
    n = 0;
    in_data  = w;
    in_valid = 1'b1;
    @(negedge clock);
    while (!in_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) check("send_timeout", 64'(in_ready), 64'd1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 500) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (3) @(posedge clock);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Header then data, consecutive output cycles, level peaks at 2
    peak = 0;
    expect_w(64'h2000_0000_0000_0001);
    expect_w(64'h0000_0000_0000_00AA);
    send(64'h2000_0000_0000_0001);
    check("hdr_held_not_out", 64'(out_valid), 64'd0);
    send(64'h0000_0000_0000_00AA);
    check("pair_head", out_data, 64'h2000_0000_0000_0001);
    check("pair_level", 64'(fifo_level), 64'd2);
    @(posedge clock);
    #1;
    check("pair_second", out_data, 64'h0000_0000_0000_00AA);
    check("pair_level_after_pop", 64'(fifo_level), 64'd1);
    drain();
    check("pair_peak", 64'(peak), 64'd2);

    // Empty event: H1 dropped
    expect_w(64'h2000_0000_0000_0022);
    expect_w(64'h0000_0000_0000_00BB);
    send(64'h2000_0000_0000_0011);
    send(64'h2000_0000_0000_0022);
    send(64'h0000_0000_0000_00BB);
    drain();
`ifdef KEEPBACK_STATS_EN
    check("stats_empty_1", 64'(empty_evt_cnt), 64'd1);
    check("stats_event_2", 64'(event_cnt), 64'd2);
`endif

    // Backpressure: orphan + three pairs reaches level 7, in_ready drops
    out_ready = 1'b0;
    expect_w(64'h0000_0000_0000_00C0);
    send(64'h0000_0000_0000_00C0);
    for (int i = 1; i <= 3; i++) begin
      expect_w(64'h2000_0000_0000_0100 + 64'(i));
      expect_w(64'h0000_0000_0000_0C00 + 64'(i));
      send(64'h2000_0000_0000_0100 + 64'(i));
      send(64'h0000_0000_0000_0C00 + 64'(i));
      if (i == 2) begin
        @(negedge clock);
        check("bp_level5", 64'(fifo_level), 64'd5);
        check("bp_ready_at5", 64'(in_ready), 64'd1);
      end
    end
    @(negedge clock);
    check("bp_level7", 64'(fifo_level), 64'd7);
    check("bp_ready_at7", 64'(in_ready), 64'd0);
    repeat (3) @(negedge clock);
    check("bp_hold_data", out_data, 64'h0000_0000_0000_00C0);
    check("bp_level_hold", 64'(fifo_level), 64'd7);
    out_ready = 1'b1;
    drain();
`ifdef KEEPBACK_STATS_EN
    check("stats_event_5", 64'(event_cnt), 64'd5);
`endif

    // Pass-through: H, H, D all forwarded
    enable = 1'b0;
    expect_w(64'h2000_0000_0000_0A01);
    expect_w(64'h2000_0000_0000_0A02);
    expect_w(64'h0000_0000_0000_0A03);
    send(64'h2000_0000_0000_0A01);
    send(64'h2000_0000_0000_0A02);
    send(64'h0000_0000_0000_0A03);
    drain();
    // Enable falls while HELD: header dropped, next data is an orphan
    enable = 1'b1;
    send(64'h2000_0000_0000_0B01);
    enable = 1'b0;
    @(posedge clock);
    #1;
    enable = 1'b1;
    expect_w(64'h0000_0000_0000_0B02);
    send(64'h0000_0000_0000_0B02);
    drain();
`ifdef KEEPBACK_STATS_EN
    check("stats_empty_2", 64'(empty_evt_cnt), 64'd2);
    check("stats_event_5b", 64'(event_cnt), 64'd5);
`endif

    // Reset mid-event with 5 words queued and a header held
    out_ready = 1'b0;
    send(64'h0000_0000_0000_0D01);
    send(64'h2000_0000_0000_0D02);
    send(64'h0000_0000_0000_0D03);
    send(64'h2000_0000_0000_0D04);
    send(64'h0000_0000_0000_0D05);
    send(64'h2000_0000_0000_0D06);
    @(negedge clock);
    check("mid_level5", 64'(fifo_level), 64'd5);
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_level", 64'(fifo_level), 64'd0);
    check("mid_rst_ready", 64'(in_ready), 64'd0);
    check("mid_rst_data", out_data, 64'd0);
`ifdef KEEPBACK_STATS_EN
    check("mid_rst_empty_cnt", 64'(empty_evt_cnt), 64'd0);
    check("mid_rst_event_cnt", 64'(event_cnt), 64'd0);
`endif
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    check("rel_in_ready", 64'(in_ready), 64'd1);
    check("rel_out_valid", 64'(out_valid), 64'd0);
    expect_w(64'h0000_0000_0000_0E01);
    send(64'h0000_0000_0000_0E01);
    check("lat_valid", 64'(out_valid), 64'd1);
    check("lat_data", out_data, 64'h0000_0000_0000_0E01);
    drain();

    // Orphans in IDLE, then a normal pair proves state stayed IDLE
    expect_w(64'h0000_0000_0000_0F01);
    expect_w(64'h0000_0000_0000_0F02);
    send(64'h0000_0000_0000_0F01);
    send(64'h0000_0000_0000_0F02);
    drain();
    expect_w(64'h2000_0000_0000_0F03);
    expect_w(64'h0000_0000_0000_0F04);
    send(64'h2000_0000_0000_0F03);
    check("idle_hdr_held", 64'(out_valid), 64'd0);
    send(64'h0000_0000_0000_0F04);
    drain();

    check("final_queue", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
